ex_muldiv: RTL

Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It takes the two operand values and the destination register index held in ID/EX and computes a 16-bit multiply, multiply-high, unsigned divide or unsigned remainder over several cycles. While it works it raises a hold request, so the pipeline controller freezes ID/EX and the upstream stages. It delivers a registered result together with a one-cycle `done` pulse.

---
 rtl/ex_muldiv.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv.sv
// Iterative 16-bit multiply / unsigned divide unit for the EX stage.
// Stalls the pipeline while iterating and returns a registered result with a done pulse.
//
// state  | meaning
// IDLE   | waiting for a mul/div instruction in ID/EX
// MUL    | shift-add multiply, one multiplier bit per cycle
// DIV    | restoring divide, one quotient bit per cycle, MSB first
// DONE   | result valid, done pulse, ID/EX advances at end of cycle
module ex_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [2:0]       rd_in,
  output logic             hold_req,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       rd_out
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sel_hi_q, sel_hi_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2:0]         rd_lat_q, rd_lat_d;
  logic [2:0]         rd_q, rd_d;
  logic [WIDTH-1:0]   res_q, res_d;

  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic               last_iter;

  // Multiply: acc holds the partial product; add into the high half, then shift right.
  // Divide: acc holds {remainder, dividend/quotient}; shift left one bit per step.
  always_comb begin
    mul_addend = b_q[0] ? a_q : '0;
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    mul_next   = {mul_sum, acc_q[WIDTH-1:1]};

    div_shift  = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff   = div_shift[WIDTH-1:0] - b_q;
    if (div_shift >= {1'b0, b_q}) begin
      div_next = {div_diff, acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end

    last_iter  = (cnt_q == CW'(1));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_hi_d = sel_hi_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    rd_lat_d = rd_lat_q;
    rd_d     = rd_q;
    res_d    = res_q;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          sel_hi_d = op[0];
          a_d      = src_a;
          b_d      = src_b;
          rd_lat_d = rd_in;
          cnt_d    = CW'(WIDTH);
          acc_d    = op[1] ? {{WIDTH{1'b0}}, src_a} : '0;
          if (!op[1]) begin
            state_d = S_MUL;
          end else if (src_b != '0) begin
            state_d = S_DIV;
          end else begin
            // Divide by zero completes immediately: quotient all-ones, remainder = dividend.
            state_d = S_DONE;
            res_d   = op[0] ? src_a : '1;
            rd_d    = rd_in;
          end
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = mul_next;
          b_d   = b_q >> 1;
          cnt_d = cnt_q - CW'(1);
          if (last_iter) begin
            state_d = S_DONE;
            res_d   = sel_hi_q ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];
            rd_d    = rd_lat_q;
          end
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = div_next;
          cnt_d = cnt_q - CW'(1);
          if (last_iter) begin
            state_d = S_DONE;
            res_d   = sel_hi_q ? div_next[2*WIDTH-1:WIDTH] : div_next[WIDTH-1:0];
            rd_d    = rd_lat_q;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sel_hi_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      rd_lat_q <= '0;
      rd_q     <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_hi_q <= sel_hi_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      rd_lat_q <= rd_lat_d;
      rd_q     <= rd_d;
      res_q    <= res_d;
    end
  end

  // hold_req is combinational so the stall covers the acceptance cycle itself.
  always_comb begin
    busy     = (state_q == S_MUL) || (state_q == S_DIV);
    done     = (state_q == S_DONE);
    hold_req = ((state_q == S_IDLE) && start && !flush) || busy;
    result   = res_q;
    rd_out   = rd_q;
  end

endmodule
